dual_issue_decoder: RTL and testbench

Parametrised dual-issue decode/issue stage of the SPU pipeline, between instruction fetch and the even/odd execution pipes. Accepts an instruction pair per handshake, routes each slot to its pipe by opcode parity, and splits same-pipe pairs over two cycles. It extracts register and immediate fields and tracks even-pipe occupancy for multi-cycle operations.

---
 rtl/spu_decode_pkg.sv | 36 +++
 rtl/dual_issue_decoder_if.sv | 40 ++++
 rtl/inst_field_decode.sv | 33 +++
 rtl/dual_issue_decoder.sv | 167 ++++++++++++++++
 tb/tb_dual_issue_decoder.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/spu_decode_pkg.sv
// rtl/spu_decode_pkg.sv - shared constants, field offsets and state type for the SPU dual-issue decoder
// Purpose : opcode constants, empty-slot word, field positions and the RUN/SPLIT state enum.
// Ports   : none (package).
package spu_decode_pkg;

  localparam int ADDR_W_DEF    = 7;
  localparam int INST_W_DEF    = 32;
  localparam int OP_W_DEF      = 6;
  localparam int IMM_W_DEF     = 10;
  localparam int OP_MUL        = 20;
  localparam int MUL_STALL_DEF = 1;

  // Busy counter width covers mulStall values 1..7.
  localparam int BUSY_W = 3;

  // An all-ones word marks an empty slot.
  localparam logic [INST_W_DEF-1:0] NOP_WORD = '1;

  // Field positions in units of the register address width; the immediate
  // starts where rb starts.
  localparam int RD_FIELD  = 0;
  localparam int RA_FIELD  = 1;
  localparam int RB_FIELD  = 2;
  localparam int IMM_FIELD = 2;

  // Decoder instance indices: two incoming slots and the hold register.
  localparam logic [1:0] SRC_SLOT0 = 2'd0;
  localparam logic [1:0] SRC_SLOT1 = 2'd1;
  localparam logic [1:0] SRC_HOLD  = 2'd2;

  typedef enum logic {
    RUN   = 1'b0,
    SPLIT = 1'b1
  } state_e;

endpackage

// File: rtl/dual_issue_decoder_if.sv
// rtl/dual_issue_decoder_if.sv - fetch-side handshake and per-pipe issue bus of the dual-issue decoder
// Purpose : groups the instruction-pair handshake and the even/odd issue outputs.
// Ports   : master = fetch/consumer side (drives stallIn, instValid, instIn);
//           slave  = decoder (drives instReady and all issue outputs).
interface dual_issue_decoder_if
  import spu_decode_pkg::*;
#(
  parameter int addrWidth = ADDR_W_DEF,
  parameter int instWidth = INST_W_DEF,
  parameter int opWidth   = OP_W_DEF,
  parameter int immWidth  = IMM_W_DEF
);
  logic                   stallIn;
  logic                   instValid;
  logic [2*instWidth-1:0] instIn;
  logic                   instReady;

  logic                   validEven,   validOdd;
  logic [opWidth-1:0]     opOutEven,   opOutOdd;
  logic [addrWidth-1:0]   raEven,      raOdd;
  logic [addrWidth-1:0]   rbEven,      rbOdd;
  logic [addrWidth-1:0]   rdEven,      rdOdd;
  logic [immWidth-1:0]    immeNumEven, immeNumOdd;
  logic                   immeSelEven, immeSelOdd;

  modport master (
    output stallIn, instValid, instIn,
    input  instReady,
    input  validEven, opOutEven, raEven, rbEven, rdEven, immeNumEven, immeSelEven,
    input  validOdd,  opOutOdd,  raOdd,  rbOdd,  rdOdd,  immeNumOdd,  immeSelOdd
  );

  modport slave (
    input  stallIn, instValid, instIn,
    output instReady,
    output validEven, opOutEven, raEven, rbEven, rdEven, immeNumEven, immeSelEven,
    output validOdd,  opOutOdd,  raOdd,  rbOdd,  rdOdd,  immeNumOdd,  immeSelOdd
  );

endinterface

// File: rtl/inst_field_decode.sv
// rtl/inst_field_decode.sv - combinational single-slot field extraction and pipe select
// Purpose : splits one instruction word into opcode, register fields and immediate.
// Ports   : inst_i word in; valid_o (slot not empty), odd_o (odd pipe), op_o, ra_o,
//           rb_o, rd_o, imm_o (zero for non-immediate ops), imm_sel_o.
module inst_field_decode
  import spu_decode_pkg::*;
#(
  parameter int addrWidth = ADDR_W_DEF,
  parameter int instWidth = INST_W_DEF,
  parameter int opWidth   = OP_W_DEF,
  parameter int immWidth  = IMM_W_DEF
) (
  input  logic [instWidth-1:0] inst_i,
  output logic                 valid_o,
  output logic                 odd_o,
  output logic [opWidth-1:0]   op_o,
  output logic [addrWidth-1:0] ra_o,
  output logic [addrWidth-1:0] rb_o,
  output logic [addrWidth-1:0] rd_o,
  output logic [immWidth-1:0]  imm_o,
  output logic                 imm_sel_o
);

  assign op_o      = inst_i[instWidth-1 -: opWidth];
  assign valid_o   = ~&inst_i;
  assign odd_o     = op_o[0];
  assign imm_sel_o = op_o[1];
  assign rd_o      = inst_i[RD_FIELD*addrWidth +: addrWidth];
  assign ra_o      = inst_i[RA_FIELD*addrWidth +: addrWidth];
  assign rb_o      = inst_i[RB_FIELD*addrWidth +: addrWidth];
  assign imm_o     = imm_sel_o ? inst_i[IMM_FIELD*addrWidth +: immWidth] : '0;

endmodule

// File: rtl/dual_issue_decoder.sv
// rtl/dual_issue_decoder.sv - dual-issue decode/issue stage routing a slot pair to the even/odd pipes
// Purpose : accepts an instruction pair, issues each slot to its pipe by opcode parity,
//           splits same-pipe pairs over two cycles and tracks even-pipe busy cycles.
// Ports   : clk, reset (async, active-low); bus (slave modport): stallIn, instValid,
//           instIn, instReady, and per-pipe valid/op/ra/rb/rd/immeNum/immeSel.
// Config  : STRUCT_HAZARD_EN enables the even-pipe busy counter for mulOp.
module dual_issue_decoder
  import spu_decode_pkg::*;
#(
  parameter int addrWidth = ADDR_W_DEF,
  parameter int instWidth = INST_W_DEF,
  parameter int opWidth   = OP_W_DEF,
  parameter int immWidth  = IMM_W_DEF,
  parameter int mulOp     = OP_MUL,
  parameter int mulStall  = MUL_STALL_DEF
) (
  input logic                 clk,
  input logic                 reset,
  dual_issue_decoder_if.slave bus
);

  state_e               state_q, state_d;
  logic [instWidth-1:0] hold_q, hold_d;
  logic [BUSY_W-1:0]    busy_q;

  logic [instWidth-1:0] dec_in    [3];
  logic                 dec_valid [3];
  logic                 dec_odd   [3];
  logic [opWidth-1:0]   dec_op    [3];
  logic [addrWidth-1:0] dec_ra    [3];
  logic [addrWidth-1:0] dec_rb    [3];
  logic [addrWidth-1:0] dec_rd    [3];
  logic [immWidth-1:0]  dec_imm   [3];
  logic                 dec_sel   [3];

  assign dec_in[SRC_SLOT0] = bus.instIn[instWidth-1:0];
  assign dec_in[SRC_SLOT1] = bus.instIn[2*instWidth-1:instWidth];
  assign dec_in[SRC_HOLD]  = hold_q;

  for (genvar g = 0; g < 3; g++) begin : g_dec
    inst_field_decode #(
      .addrWidth(addrWidth), .instWidth(instWidth),
      .opWidth(opWidth),     .immWidth(immWidth)
    ) u_dec (
      .inst_i   (dec_in[g]),
      .valid_o  (dec_valid[g]),
      .odd_o    (dec_odd[g]),
      .op_o     (dec_op[g]),
      .ra_o     (dec_ra[g]),
      .rb_o     (dec_rb[g]),
      .rd_o     (dec_rd[g]),
      .imm_o    (dec_imm[g]),
      .imm_sel_o(dec_sel[g])
    );
  end

  logic accept;
  assign bus.instReady = ~bus.stallIn & (state_q == RUN) & (busy_q == '0);
  assign accept        = bus.instValid & bus.instReady;

  logic       even_go, odd_go;
  logic [1:0] even_src, odd_src;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    even_go  = 1'b0;
    odd_go   = 1'b0;
    even_src = SRC_SLOT0;
    odd_src  = SRC_SLOT0;
    if (!bus.stallIn) begin
      if (state_q == RUN) begin
        if (accept) begin
          if (dec_odd[SRC_SLOT0]) begin
            if (dec_valid[SRC_SLOT0]) begin odd_go = 1'b1; odd_src = SRC_SLOT0; end
          end else if (dec_valid[SRC_SLOT0]) begin
            even_go = 1'b1; even_src = SRC_SLOT0;
          end
          if (dec_valid[SRC_SLOT0] && dec_valid[SRC_SLOT1] &&
              (dec_odd[SRC_SLOT0] == dec_odd[SRC_SLOT1])) begin
            // Same-pipe pair: the younger slot waits one cycle in the hold register.
            hold_d  = dec_in[SRC_SLOT1];
            state_d = SPLIT;
          end else if (dec_valid[SRC_SLOT1]) begin
            if (dec_odd[SRC_SLOT1]) begin odd_go = 1'b1; odd_src = SRC_SLOT1; end
            else begin even_go = 1'b1; even_src = SRC_SLOT1; end
          end
        end
      end else if (!dec_valid[SRC_HOLD] || dec_odd[SRC_HOLD] || (busy_q == '0)) begin
        // Held even slot waits for the multi-cycle op to drain; odd never waits.
        state_d = RUN;
        hold_d  = '1;
        if (dec_valid[SRC_HOLD]) begin
          if (dec_odd[SRC_HOLD]) begin odd_go = 1'b1; odd_src = SRC_HOLD; end
          else begin even_go = 1'b1; even_src = SRC_HOLD; end
        end
      end
    end
  end

`ifdef STRUCT_HAZARD_EN
  logic [BUSY_W-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (even_go && (dec_op[even_src] == opWidth'(mulOp))) busy_d = BUSY_W'(mulStall);
    else if (busy_q != '0) busy_d = busy_q - BUSY_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy_q <= '0;
    else if (!bus.stallIn) busy_q <= busy_d;
  end
`else
  assign busy_q = '0;
`endif

  logic                 valid_even_q, valid_odd_q;
  logic [opWidth-1:0]   op_even_q,    op_odd_q;
  logic [addrWidth-1:0] ra_even_q,    ra_odd_q;
  logic [addrWidth-1:0] rb_even_q,    rb_odd_q;
  logic [addrWidth-1:0] rd_even_q,    rd_odd_q;
  logic [immWidth-1:0]  imm_even_q,   imm_odd_q;
  logic                 sel_even_q,   sel_odd_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RUN;
      hold_q       <= '1;
      valid_even_q <= 1'b0; op_even_q <= '0; ra_even_q <= '0; rb_even_q <= '0;
      rd_even_q    <= '0;   imm_even_q <= '0; sel_even_q <= 1'b0;
      valid_odd_q  <= 1'b0; op_odd_q  <= '0; ra_odd_q  <= '0; rb_odd_q  <= '0;
      rd_odd_q     <= '0;   imm_odd_q  <= '0; sel_odd_q  <= 1'b0;
    end else if (!bus.stallIn) begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      valid_even_q <= even_go;
      valid_odd_q  <= odd_go;
      if (even_go) begin
        op_even_q  <= dec_op[even_src];  ra_even_q  <= dec_ra[even_src];
        rb_even_q  <= dec_rb[even_src];  rd_even_q  <= dec_rd[even_src];
        imm_even_q <= dec_imm[even_src]; sel_even_q <= dec_sel[even_src];
      end
      if (odd_go) begin
        op_odd_q  <= dec_op[odd_src];  ra_odd_q  <= dec_ra[odd_src];
        rb_odd_q  <= dec_rb[odd_src];  rd_odd_q  <= dec_rd[odd_src];
        imm_odd_q <= dec_imm[odd_src]; sel_odd_q <= dec_sel[odd_src];
      end
    end
  end

  assign bus.validEven   = valid_even_q;
  assign bus.opOutEven   = op_even_q;
  assign bus.raEven      = ra_even_q;
  assign bus.rbEven      = rb_even_q;
  assign bus.rdEven      = rd_even_q;
  assign bus.immeNumEven = imm_even_q;
  assign bus.immeSelEven = sel_even_q;
  assign bus.validOdd    = valid_odd_q;
  assign bus.opOutOdd    = op_odd_q;
  assign bus.raOdd       = ra_odd_q;
  assign bus.rbOdd       = rb_odd_q;
  assign bus.rdOdd       = rd_odd_q;
  assign bus.immeNumOdd  = imm_odd_q;
  assign bus.immeSelOdd  = sel_odd_q;

endmodule

// File: tb/tb_dual_issue_decoder.sv
// tb/tb_dual_issue_decoder.sv - self-checking bench for dual_issue_decoder against a transaction-level model
module tb_dual_issue_decoder;

  localparam logic [31:0] EMPTY = 32'hFFFF_FFFF;
`ifdef STRUCT_HAZARD_EN
  localparam bit HAZARD = 1'b1;
`else
  localparam bit HAZARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dual_issue_decoder_if bus ();

  dual_issue_decoder dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: pending held instructions, remaining busy cycles, and the
  // instruction word expected on each pipe after the last clock edge.
  logic [31:0] m_hold[$];
  int          m_busy = 0;
  bit          e_ve = 0, e_vo = 0;
  logic [31:0] e_we = '0, e_wo = '0;

  function automatic int opc(input logic [31:0] w);
    return int'((w >> 26) & 32'h3F);
  endfunction

  function automatic bit is_odd(input logic [31:0] w);
    return (opc(w) % 2) == 1;
  endfunction

  function automatic logic [31:0] mk_r(input int op, input int rd, input int ra, input int rb);
    return 32'((op << 26) | (rb << 14) | (ra << 7) | rd);
  endfunction

  function automatic logic [31:0] mk_i(input int op, input int imm, input int ra, input int rd);
    return 32'((op << 26) | (imm << 14) | (ra << 7) | rd);
  endfunction

  task automatic model_issue(input logic [31:0] w);
    if (is_odd(w)) begin e_vo = 1; e_wo = w; end
    else begin e_ve = 1; e_we = w; end
  endtask

  task automatic model_step(input bit st, input bit v, input logic [31:0] w0, input logic [31:0] w1);
    bit ready;
    if (st) return;
    ready = (m_hold.size() == 0) && (m_busy == 0);
    e_ve = 0;
    e_vo = 0;
    if (m_hold.size() != 0) begin
      if (is_odd(m_hold[0]) || m_busy == 0) model_issue(m_hold.pop_front());
    end else if (v && ready) begin
      if (w0 != EMPTY && w1 != EMPTY && is_odd(w0) == is_odd(w1)) begin
        model_issue(w0);
        m_hold.push_back(w1);
      end else begin
        if (w0 != EMPTY) model_issue(w0);
        if (w1 != EMPTY) model_issue(w1);
      end
    end
    m_busy = (m_busy > 0) ? m_busy - 1 : 0;
    if (HAZARD && e_ve && opc(e_we) == 20) m_busy = 1;
  endtask

  task automatic check_pipe(input string tag, input bit odd);
    logic [31:0] w;
    int sel;
    w   = odd ? e_wo : e_we;
    sel = (opc(w) >> 1) & 1;
    if (odd) begin
      expect_eq({tag, ".opOdd"},  bus.opOutOdd,   opc(w));
      expect_eq({tag, ".rdOdd"},  bus.rdOdd,      w & 32'h7F);
      expect_eq({tag, ".raOdd"},  bus.raOdd,      (w >> 7) & 32'h7F);
      expect_eq({tag, ".rbOdd"},  bus.rbOdd,      (w >> 14) & 32'h7F);
      expect_eq({tag, ".immOdd"}, bus.immeNumOdd, sel != 0 ? ((w >> 14) & 32'h3FF) : 0);
      expect_eq({tag, ".selOdd"}, bus.immeSelOdd, sel);
    end else begin
      expect_eq({tag, ".opEven"},  bus.opOutEven,   opc(w));
      expect_eq({tag, ".rdEven"},  bus.rdEven,      w & 32'h7F);
      expect_eq({tag, ".raEven"},  bus.raEven,      (w >> 7) & 32'h7F);
      expect_eq({tag, ".rbEven"},  bus.rbEven,      (w >> 14) & 32'h7F);
      expect_eq({tag, ".immEven"}, bus.immeNumEven, sel != 0 ? ((w >> 14) & 32'h3FF) : 0);
      expect_eq({tag, ".selEven"}, bus.immeSelEven, sel);
    end
  endtask

  // Called just after a falling edge: drive inputs, check the state left by the
  // previous rising edge, advance the model, then move to the next falling edge.
  task automatic step(input bit st, input bit v, input logic [31:0] w0, input logic [31:0] w1,
                      input string tag);
    bus.stallIn   = st;
    bus.instValid = v;
    bus.instIn    = {w1, w0};
    #1;
    expect_eq({tag, ".ready"},     bus.instReady, !st && m_hold.size() == 0 && m_busy == 0);
    expect_eq({tag, ".validEven"}, bus.validEven, e_ve);
    expect_eq({tag, ".validOdd"},  bus.validOdd,  e_vo);
    if (e_ve) check_pipe(tag, 1'b0);
    if (e_vo) check_pipe(tag, 1'b1);
    model_step(st, v, w0, w1);
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    expect_eq({tag, ".validEven"}, bus.validEven,   0);
    expect_eq({tag, ".validOdd"},  bus.validOdd,    0);
    expect_eq({tag, ".opEven"},    bus.opOutEven,   0);
    expect_eq({tag, ".opOdd"},     bus.opOutOdd,    0);
    expect_eq({tag, ".regsEven"},  {bus.raEven, bus.rbEven, bus.rdEven}, 0);
    expect_eq({tag, ".regsOdd"},   {bus.raOdd, bus.rbOdd, bus.rdOdd},    0);
    expect_eq({tag, ".immEven"},   {bus.immeNumEven, bus.immeSelEven},   0);
    expect_eq({tag, ".immOdd"},    {bus.immeNumOdd, bus.immeSelOdd},     0);
  endtask

  function automatic logic [31:0] rand_word();
    int r;
    int op;
    r = int'($urandom_range(0, 7));
    if (r == 0) return EMPTY;
    op = (r == 1) ? 20 : int'($urandom_range(0, 62));
    return 32'(($urandom & 32'h03FF_FFFF) | (op << 26));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.stallIn   = 1'b0;
    bus.instValid = 1'b0;
    bus.instIn    = '0;
    reset         = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    expect_eq("reset.ready", bus.instReady, 1);
    reset = 1'b1;
    @(negedge clk);

    // Different pipes: both issue, ready stays high.
    step(0, 1, mk_r(4, 3, 5, 7), mk_r(1, 9, 10, 11), "diff");
    expect_eq("diff.rbEven", bus.rbEven, 7);
    expect_eq("diff.bothValid", {bus.validEven, bus.validOdd}, 2'b11);
    expect_eq("diff.readyStill", bus.instReady, 1);
    step(0, 0, EMPTY, EMPTY, "diff_idle");

    // Same-pipe pair with immediate on slot0.
    step(0, 1, mk_i(6, 'h155, 2, 1), mk_r(10, 4, 5, 6), "split");
    expect_eq("split.immEven", bus.immeNumEven, 'h155);
    expect_eq("split.selEven", bus.immeSelEven, 1);
    expect_eq("split.readyLow", bus.instReady, 0);
    step(0, 0, EMPTY, EMPTY, "split2");
    expect_eq("split2.opEven", bus.opOutEven, 10);
    step(0, 0, EMPTY, EMPTY, "split_idle");

    // Multi-cycle op with empty slot1.
    step(0, 1, mk_r(20, 1, 2, 3), EMPTY, "mul");
    expect_eq("mul.validEven", bus.validEven, 1);
    expect_eq("mul.ready", bus.instReady, HAZARD ? 0 : 1);
    step(0, 1, mk_r(20, 4, 4, 4), mk_r(3, 5, 5, 5), "mul_next");
    step(0, 1, mk_r(8, 6, 6, 6), mk_r(20, 7, 7, 7), "mul_after");
    step(0, 0, EMPTY, EMPTY, "mul_idle1");
    step(0, 0, EMPTY, EMPTY, "mul_idle2");

    // Stall during SPLIT.
    step(0, 1, mk_r(12, 1, 1, 1), mk_r(16, 2, 2, 2), "stall");
    for (int i = 0; i < 3; i++) step(1, 1, mk_r(2, 0, 0, 0), EMPTY, "stall_hold");
    expect_eq("stall.frozenValid", bus.validEven, 1);
    expect_eq("stall.frozenOp", bus.opOutEven, 12);
    step(0, 0, EMPTY, EMPTY, "stall_release");
    expect_eq("stall.heldOp", bus.opOutEven, 16);
    step(0, 0, EMPTY, EMPTY, "stall_idle");

    // Both slots empty.
    step(0, 1, EMPTY, EMPTY, "empty");
    expect_eq("empty.noValid", {bus.validEven, bus.validOdd}, 0);
    step(0, 0, EMPTY, EMPTY, "empty_idle");

    // Asynchronous reset while a held slot is pending.
    step(0, 1, mk_r(24, 3, 3, 3), mk_r(28, 4, 4, 4), "rst_split");
    #2 reset = 1'b0;
    #1 check_zero("async_reset");
    m_hold.delete();
    m_busy = 0;
    e_ve   = 0;
    e_vo   = 0;
    @(negedge clk);
    reset = 1'b1;
    step(0, 0, EMPTY, EMPTY, "post_reset1");
    step(0, 0, EMPTY, EMPTY, "post_reset2");

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 4) == 0), ($urandom_range(0, 3) != 0), rand_word(), rand_word(), "rand");
    end
    step(0, 0, EMPTY, EMPTY, "final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
